// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480 @ 60 Hz VGA path: pixel coordinates, sync pulses,
// the visible-pixel qualifier, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HLast      = 10'(HTotal - 1);
    localparam logic [9:0] VLast      = 10'(VTotal - 1);
    localparam logic [9:0] HVis       = 10'(H_VISIBLE);
    localparam logic [9:0] VVis       = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       h_wrap;

    // Decoded outputs come from the next-state counters so they land in the same cycle as DrawX/Y.
    always_comb begin
        h_wrap = (hc_q == HLast);
        hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d   = vc_q;
        if (h_wrap) begin
            vc_d = (vc_q == VLast) ? 10'd0 : vc_q + 10'd1;
        end

        hs_d          = !((hc_d >= HSyncStart) && (hc_d < HSyncEnd));
        vs_d          = !((vc_d >= VSyncStart) && (vc_d < VSyncEnd));
        blank_d       = (hc_d < HVis) && (vc_d < VVis);
        line_start_d  = (hc_d == 10'd0);
        frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    // Reset parks the raster on the last pixel so the first released edge starts frame 0 cleanly.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q          <= HLast;
            vc_q          <= VLast;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-size instance for reset and line timing, and a shrunken-raster
// instance (15x13) for frame-level timing, the 256-frame counter wrap and mid-frame reset.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_d, rst_s;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_hs, d_vs, d_blank, d_ls, d_fs;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [7:0] d_fc, s_fc;

    int total = 0;
    int bad   = 0;

    vga_timing_gen u_dut (
        .vga_clk(clk), .reset_n(rst_d), .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs),
        .blank(d_blank), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    // Small raster: H 8+2+3+2 = 15, V 6+2+2+3 = 13, frame = 195 cycles.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_small (
        .vga_clk(clk), .reset_n(rst_s), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
        .blank(s_blank), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_low, hs_err, bl_err, ls_err, x_err;
        int e_x, e_y, e_hs, e_vs, e_bl, e_ls, e_fs, e_fc, vs_low, fs_cnt, fs_gap, last_fs;
        int ex, ey, efc;

        rst_d = 1'b0;
        rst_s = 1'b0;
        step(5);

        // Default instance: reset state
        chk("rst_x", d_x, 799);
        chk("rst_y", d_y, 524);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_blank", d_blank, 0);
        chk("rst_ls", d_ls, 0);
        chk("rst_fs", d_fs, 0);
        chk("rst_fc", d_fc, 0);

        rst_d = 1'b1;
        step(1);
        chk("rel_x", d_x, 0);
        chk("rel_y", d_y, 0);
        chk("rel_blank", d_blank, 1);
        chk("rel_ls", d_ls, 1);
        chk("rel_fs", d_fs, 1);
        chk("rel_fc", d_fc, 1);
        chk("rel_hs", d_hs, 1);
        chk("rel_vs", d_vs, 1);

        // One full line on line 0
        hs_low = 0; hs_err = 0; bl_err = 0; ls_err = 0; x_err = 0;
        for (int i = 0; i < 800; i++) begin
            if (d_x !== 10'(i) || d_y !== 10'd0) x_err++;
            if (d_hs === 1'b0) hs_low++;
            if (d_hs !== !(i >= 656 && i < 752)) hs_err++;
            if (d_blank !== (i < 640)) bl_err++;
            if (d_ls !== (i == 0)) ls_err++;
            step(1);
        end
        chk("line_pos", x_err, 0);
        chk("hs_low_cycles", hs_low, 96);
        chk("hs_window", hs_err, 0);
        chk("blank_window", bl_err, 0);
        chk("ls_only_at_x0", ls_err, 0);
        chk("line_wrap_x", d_x, 0);
        chk("line_wrap_y", d_y, 1);
        chk("ls_period_800", d_ls, 1);
        chk("line1_fs", d_fs, 0);

        // Default instance mid-line reset while hs is low
        step(700);
        chk("mid_hs_low", d_hs, 0);
        rst_d = 1'b0;
        step(1);
        chk("mid_rst_x", d_x, 799);
        chk("mid_rst_y", d_y, 524);
        chk("mid_rst_hs", d_hs, 1);
        chk("mid_rst_fc", d_fc, 0);

        // Small instance: reset, release, then 256 frames against a position model
        chk("s_rst_x", s_x, 14);
        chk("s_rst_y", s_y, 12);
        rst_s = 1'b1;
        step(1);
        e_x = 0; e_y = 0; e_hs = 0; e_vs = 0; e_bl = 0; e_ls = 0; e_fs = 0; e_fc = 0;
        vs_low = 0; fs_cnt = 0; fs_gap = 0; last_fs = -1;
        for (int c = 0; c < 256 * 195; c++) begin
            ex  = c % 15;
            ey  = (c / 15) % 13;
            efc = ((c / 195) + 1) % 256;
            if (s_x !== 10'(ex)) e_x++;
            if (s_y !== 10'(ey)) e_y++;
            if (s_hs !== !(ex >= 10 && ex < 13)) e_hs++;
            if (s_vs !== !(ey >= 8 && ey < 10)) e_vs++;
            if (s_blank !== (ex < 8 && ey < 6)) e_bl++;
            if (s_ls !== (ex == 0)) e_ls++;
            if (s_fs !== (ex == 0 && ey == 0)) e_fs++;
            if (s_fc !== 8'(efc)) e_fc++;
            if (s_vs === 1'b0) vs_low++;
            if (s_fs === 1'b1) begin
                if (last_fs >= 0 && c - last_fs != 195) fs_gap++;
                last_fs = c;
                fs_cnt++;
            end
            if (c == 90) begin
                chk("s_wrap_to_y6_x", s_x, 0);
                chk("s_wrap_to_y6_y", s_y, 6);
                chk("s_wrap_to_y6_blank", s_blank, 0);
            end
            if (c == 195) begin
                chk("s_frame_wrap_xy", {s_x, s_y}, 0);
                chk("s_frame_wrap_blank", s_blank, 1);
                chk("s_frame_wrap_fs", s_fs, 1);
            end
            if (c == 255 * 195) chk("s_fc_wrap_0", s_fc, 0);
            step(1);
        end
        chk("s_x_track", e_x, 0);
        chk("s_y_track", e_y, 0);
        chk("s_hs_track", e_hs, 0);
        chk("s_vs_track", e_vs, 0);
        chk("s_blank_track", e_bl, 0);
        chk("s_ls_track", e_ls, 0);
        chk("s_fs_track", e_fs, 0);
        chk("s_fc_track", e_fc, 0);
        chk("s_vs_low_cycles", vs_low, 2 * 15 * 256);
        chk("s_fs_count", fs_cnt, 256);
        chk("s_fs_period", fs_gap, 0);
        chk("s_fc_after_256", s_fc, 1);

        // Small instance: reset mid-frame inside both sync pulses (x=11, y=9)
        step(9 * 15 + 11);
        chk("s_mid_hs_low", s_hs, 0);
        chk("s_mid_vs_low", s_vs, 0);
        rst_s = 1'b0;
        step(1);
        chk("s_mid_rst_x", s_x, 14);
        chk("s_mid_rst_y", s_y, 12);
        chk("s_mid_rst_syncs", {s_hs, s_vs}, 2'b11);
        chk("s_mid_rst_blank", s_blank, 0);
        chk("s_mid_rst_strobes", {s_ls, s_fs}, 2'b00);
        chk("s_mid_rst_fc", s_fc, 0);
        rst_s = 1'b1;
        step(1);
        chk("s_rerel_xy", {s_x, s_y}, 0);
        chk("s_rerel_flags", {s_blank, s_ls, s_fs, s_hs, s_vs}, 5'b11111);
        chk("s_rerel_fc", s_fc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
